// File: rtl/spi_request_arbiter_if.sv
// spi_request_arbiter_if: requester, read-back and controller-FIFO signals of
// the SPI request arbiter. The slave modport is the arbiter's view; the master
// modport is the view of the surrounding requesters and controller.
// req_data is packed so requester i occupies bits [i*DATA_W +: DATA_W].
interface spi_request_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int DATA_W = 32
);
    localparam int GW = $clog2(NREQ);

    logic [NREQ-1:0]              req_valid;
    logic [NREQ-1:0][DATA_W-1:0]  req_data;
    logic [NREQ-1:0]              req_last;
    logic [NREQ-1:0]              req_ready;
    logic [NREQ-1:0]              rsp_valid;
    logic [DATA_W-1:0]            rsp_data;
    logic                         spi_tx_valid;
    logic [DATA_W-1:0]            spi_tx_data;
    logic                         spi_tx_ready;
    logic                         spi_rx_valid;
    logic [DATA_W-1:0]            spi_rx_data;
    logic                         busy;
    logic [GW-1:0]                grant_id;
    logic                         timeout_err;

    modport master (
        output req_valid, req_data, req_last, spi_tx_ready, spi_rx_valid, spi_rx_data,
        input  req_ready, rsp_valid, rsp_data, spi_tx_valid, spi_tx_data,
               busy, grant_id, timeout_err
    );

    modport slave (
        input  req_valid, req_data, req_last, spi_tx_ready, spi_rx_valid, spi_rx_data,
        output req_ready, rsp_valid, rsp_data, spi_tx_valid, spi_tx_data,
               busy, grant_id, timeout_err
    );
endinterface

// File: rtl/spi_request_arbiter.sv
// spi_request_arbiter: shares one SPI controller transaction port among NREQ
// requesters. Round-robin, transaction-atomic: the grant is held from the
// first word until every read-back word of that transaction has returned.
// Optional drain timeout: define SPI_ARB_TIMEOUT_EN to build the drain
// watchdog (TIMEOUT_CYC); otherwise timeout_err is tied low.

module spi_request_arbiter_lane (
    input  logic sel,
    input  logic tx_open,
    input  logic rx_take,
    output logic ready,
    output logic rsp
);
    // Route the shared handshake onto this requester only while it owns the grant
    always_comb begin
        ready = sel & tx_open;
        rsp   = sel & rx_take;
    end
endmodule

module spi_request_arbiter #(
    parameter int NREQ        = 4,
    parameter int DATA_W      = 32,
    parameter int MAX_OUT     = 15,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                   S_AXI_ACLK,
    input  logic                   S_AXI_ARESET,
    spi_request_arbiter_if.slave   sif
);
    localparam int GW = $clog2(NREQ);
    localparam int CW = $clog2(MAX_OUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_FWD, S_DRAIN} state_t;

    state_t          state, state_nx;
    logic [GW-1:0]   grant_q, ptr_q, pick;
    logic [CW-1:0]   out_cnt;
    logic            any_req, room, fwd, tx_open, tx_fire, rx_dec, rx_take;
    logic            adv, abort;
    logic [NREQ-1:0] ready_v, rsp_v;

    assign fwd     = (state == S_FWD);
    assign room    = (out_cnt < CW'(MAX_OUT));
    assign tx_open = fwd & room & sif.spi_tx_ready;
    assign tx_fire = tx_open & sif.req_valid[grant_q];
    // A read-back word with nothing outstanding is stray: it neither
    // decrements the count nor reaches any requester.
    assign rx_dec  = sif.spi_rx_valid & (out_cnt != '0);
    assign rx_take = (state != S_IDLE) & rx_dec;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_cnt;
    logic          tmo_hit, terr_q;

    assign tmo_hit = !sif.spi_rx_valid && (tmo_cnt == TW'(TIMEOUT_CYC - 1));

    // Drain watchdog: counts DRAIN cycles since the last read-back word
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET || state != S_DRAIN || sif.spi_rx_valid)
            tmo_cnt <= '0;
        else
            tmo_cnt <= tmo_cnt + 1'b1;
    end

    // One-cycle abort pulse, visible the cycle after the forced return to IDLE
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) terr_q <= 1'b0;
        else              terr_q <= abort;
    end

    assign sif.timeout_err = terr_q;
`else
    assign sif.timeout_err = 1'b0;
`endif

    // Round-robin pick: first requesting index at or after the pointer
    always_comb begin
        int idx;
        idx     = 0;
        pick    = ptr_q;
        any_req = |sif.req_valid;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(ptr_q) + k) % NREQ;
            if (sif.req_valid[idx]) pick = GW'(idx);
        end
    end

    // Next state: IDLE grants, FWD forwards until the last word, DRAIN waits
    // for every read-back word (or the watchdog) before releasing the grant
    always_comb begin
        state_nx = state;
        adv      = 1'b0;
        abort    = 1'b0;
        case (state)
            S_IDLE:  if (any_req) state_nx = S_FWD;
            S_FWD:   if (tx_fire && sif.req_last[grant_q]) state_nx = S_DRAIN;
            S_DRAIN: begin
                if (out_cnt == '0) begin
                    state_nx = S_IDLE;
                    adv      = 1'b1;
                end
`ifdef SPI_ARB_TIMEOUT_EN
                else if (tmo_hit) begin
                    state_nx = S_IDLE;
                    adv      = 1'b1;
                    abort    = 1'b1;
                end
`endif
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) state <= S_IDLE;
        else              state <= state_nx;
    end

    // Grant latched only in IDLE; pointer moves past the owner on completion
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            if (state == S_IDLE && any_req) grant_q <= pick;
            if (adv) ptr_q <= (grant_q == GW'(NREQ - 1)) ? '0 : grant_q + 1'b1;
        end
    end

    // Words in flight to the controller; simultaneous tx and rx cancel
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET || abort)     out_cnt <= '0;
        else if (tx_fire && !rx_dec)   out_cnt <= out_cnt + 1'b1;
        else if (!tx_fire && rx_dec)   out_cnt <= out_cnt - 1'b1;
    end

    for (genvar i = 0; i < NREQ; i++) begin : g_lane
        spi_request_arbiter_lane u_lane (
            .sel     (grant_q == GW'(i)),
            .tx_open (tx_open),
            .rx_take (rx_take),
            .ready   (ready_v[i]),
            .rsp     (rsp_v[i])
        );
    end

    assign sif.req_ready    = ready_v;
    assign sif.rsp_valid    = rsp_v;
    assign sif.rsp_data     = rx_take ? sif.spi_rx_data : '0;
    assign sif.spi_tx_valid = fwd & room & sif.req_valid[grant_q];
    assign sif.spi_tx_data  = fwd ? sif.req_data[grant_q] : '0;
    assign sif.busy         = (state != S_IDLE);
    assign sif.grant_id     = grant_q;
endmodule

// File: tb/tb_spi_request_arbiter.sv
// tb_spi_request_arbiter: directed scenarios followed by random traffic, every
// cycle compared against a behavioural model of the arbitration rules
// (owner / draining / words-in-flight / pointer kept as plain integers).
module tb_spi_request_arbiter;
    localparam int NREQ        = 4;
    localparam int DATA_W      = 32;
    localparam int MAX_OUT     = 2;
    localparam int TIMEOUT_CYC = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_request_arbiter_if #(.NREQ(NREQ), .DATA_W(DATA_W)) sif ();

    spi_request_arbiter #(
        .NREQ(NREQ), .DATA_W(DATA_W), .MAX_OUT(MAX_OUT), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESET (rst),
        .sif          (sif)
    );

    int checks = 0;
    int errors = 0;

    // behavioural model
    int owner    = -1;
    bit draining = 1'b0;
    int inflight = 0;
    int ptr      = 0;
    int tcnt     = 0;
    bit terr_exp = 1'b0;

    // bench-side controller and observations
    bit              auto_rx = 1'b0;
    bit [1:0]        rx_dly  = 2'b00;
    int              sent    = 0;
    bit              prev_busy = 1'b0;
    logic            obs_busy, obs_terr;
    logic [NREQ-1:0] obs_ready, obs_rsp;
    int              dut_grants[$];
    int              exp2[5] = '{2, 3, 0, 1, 2};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, compare combinational outputs, advance model at posedge
    task automatic step(input logic r, input logic [NREQ-1:0] v, input logic [NREQ-1:0] l,
                        input logic txr, input logic rx_force);
        logic [NREQ-1:0][DATA_W-1:0] d;
        logic [DATA_W-1:0] rd;
        logic [NREQ-1:0]   exp_ready, exp_rsp;
        logic              exp_txv, rx_ok, xfer, rxv;
        int                old, idx;
        bit                found;
        @(negedge clk);
        rxv = rx_force | (auto_rx & rx_dly[1]);
        for (int i = 0; i < NREQ; i++) d[i] = $urandom;
        rd = $urandom;
        rst = r;
        sif.req_valid    = v;
        sif.req_last     = l;
        sif.req_data     = d;
        sif.spi_tx_ready = txr;
        sif.spi_rx_valid = rxv;
        sif.spi_rx_data  = rd;
        #1;
        exp_txv   = 1'b0;
        exp_ready = '0;
        exp_rsp   = '0;
        if (owner >= 0 && !draining && inflight < MAX_OUT) begin
            exp_txv = v[owner];
            if (txr) exp_ready[owner] = 1'b1;
        end
        rx_ok = (owner >= 0) && rxv && (inflight > 0);
        if (rx_ok) exp_rsp[owner] = 1'b1;
        chk("busy", sif.busy, owner >= 0);
        chk("req_ready", sif.req_ready, exp_ready);
        chk("tx_valid", sif.spi_tx_valid, exp_txv);
        chk("rsp_valid", sif.rsp_valid, exp_rsp);
        chk("timeout_err", sif.timeout_err, terr_exp);
        if (owner >= 0) chk("grant_id", sif.grant_id, owner);
        if (exp_txv)    chk("tx_data", sif.spi_tx_data, d[owner]);
        if (rx_ok)      chk("rsp_data", sif.rsp_data, rd);
        obs_busy  = sif.busy;
        obs_terr  = sif.timeout_err;
        obs_ready = sif.req_ready;
        obs_rsp   = sif.rsp_valid;
        if (sif.busy && !prev_busy) dut_grants.push_back(int'(sif.grant_id));
        prev_busy = sif.busy;
        if (sif.spi_tx_valid && sif.spi_tx_ready) sent++;
        xfer = exp_txv && txr;
        @(posedge clk);
        rx_dly   = r ? 2'b00 : {rx_dly[0], xfer};
        terr_exp = 1'b0;
        if (r) begin
            owner = -1; draining = 1'b0; inflight = 0; ptr = 0; tcnt = 0;
        end else begin
            old      = inflight;
            inflight = inflight + (xfer ? 1 : 0) - ((rxv && old > 0) ? 1 : 0);
            if (owner < 0) begin
                found = 1'b0;
                for (int k = 0; k < NREQ; k++) begin
                    idx = (ptr + k) % NREQ;
                    if (!found && v[idx]) begin
                        owner = idx;
                        found = 1'b1;
                    end
                end
            end else if (!draining) begin
                if (xfer && l[owner]) begin
                    draining = 1'b1;
                    tcnt     = 0;
                end
            end else if (old == 0) begin
                ptr = (owner + 1) % NREQ; owner = -1; draining = 1'b0;
            end
`ifdef SPI_ARB_TIMEOUT_EN
            else if (!rxv && tcnt == TIMEOUT_CYC - 1) begin
                inflight = 0; ptr = (owner + 1) % NREQ; owner = -1; draining = 1'b0;
                terr_exp = 1'b1;
            end else begin
                tcnt = rxv ? 0 : tcnt + 1;
            end
`endif
        end
    endtask

    initial begin
        int guard;
        int rsp1;
        logic [NREQ-1:0] rv;
        sif.req_valid    = '0;
        sif.req_last     = '0;
        sif.req_data     = '0;
        sif.spi_tx_ready = 1'b0;
        sif.spi_rx_valid = 1'b0;
        sif.spi_rx_data  = '0;

        // reset state
        step(1, 4'b0000, 4'b0000, 0, 0);
        step(1, 4'b0000, 4'b0000, 0, 0);
        #1;
        chk("rst_grant_id", sif.grant_id, 0);
        chk("rst_ready", sif.req_ready, 0);
        chk("rst_busy", sif.busy, 0);

        // single 3-word transaction from requester 1, rx two cycles after each tx
        auto_rx = 1'b1; sent = 0; rsp1 = 0;
        for (guard = 0; guard < 40; guard++) begin
            step(0, (sent < 3) ? 4'b0010 : 4'b0000, (sent == 2) ? 4'b0010 : 4'b0000, 1, 0);
            if (obs_rsp == 4'b0010) rsp1++;
            if (sent == 3 && !obs_busy) break;
        end
        chk("t1_done", guard < 40, 1);
        chk("t1_words", sent, 3);
        chk("t1_rsp_count", rsp1, 3);

        // everyone requesting, 1-word transactions: pointer was left at 2
        dut_grants.delete();
        for (guard = 0; guard < 100 && dut_grants.size() < 5; guard++)
            step(0, 4'b1111, 4'b1111, 1, 0);
        chk("t2_grant_count", dut_grants.size(), 5);
        for (int i = 0; i < 5 && i < dut_grants.size(); i++)
            chk($sformatf("t2_grant%0d", i), dut_grants[i], exp2[i]);
        for (guard = 0; guard < 30; guard++) begin
            step(0, 4'b0000, 4'b0000, 1, 0);
            if (!obs_busy) break;
        end
        chk("t2_drained", obs_busy, 0);

        // outstanding limit with read-back withheld
        step(1, 4'b0000, 4'b0000, 0, 0);
        auto_rx = 1'b0; sent = 0;
        for (int i = 0; i < 8; i++) step(0, 4'b0001, (sent == 3) ? 4'b0001 : 4'b0000, 1, 0);
        chk("t3_stall_words", sent, 2);
        chk("t3_stall_ready", obs_ready, 0);
        step(0, 4'b0001, 4'b0000, 1, 1);
        for (int i = 0; i < 5; i++) step(0, 4'b0001, 4'b0000, 1, 0);
        chk("t3_one_more", sent, 3);
        for (guard = 0; guard < 30; guard++) begin
            step(0, (sent < 4) ? 4'b0001 : 4'b0000, (sent == 3) ? 4'b0001 : 4'b0000, 1, 1);
            if (sent == 4 && !obs_busy) break;
        end
        chk("t3_done", guard < 30, 1);

        // stray rx in IDLE, then tx and rx in the same cycle at count 1
        step(1, 4'b0000, 4'b0000, 0, 0);
        step(0, 4'b0000, 4'b0000, 1, 1);
        chk("t4_stray_rsp", obs_rsp, 0);
        step(0, 4'b0100, 4'b0000, 1, 0);
        step(0, 4'b0100, 4'b0000, 1, 0);
        step(0, 4'b0100, 4'b0100, 1, 1);
        for (int i = 0; i < 3; i++) step(0, 4'b0000, 4'b0000, 1, 0);
        chk("t4_still_one_out", obs_busy, 1);
        step(0, 4'b0000, 4'b0000, 1, 1);
        step(0, 4'b0000, 4'b0000, 1, 0);
        step(0, 4'b0000, 4'b0000, 1, 0);
        chk("t4_released", obs_busy, 0);

        // reset in the middle of a 4-word transaction
        step(1, 4'b0000, 4'b0000, 0, 0);
        sent = 0;
        for (guard = 0; guard < 10 && sent < 2; guard++) step(0, 4'b1000, 4'b0000, 1, 0);
        chk("t5_two_words", sent, 2);
        step(1, 4'b1000, 4'b0000, 1, 0);
        step(0, 4'b0000, 4'b0000, 1, 1);
        chk("t5_busy", obs_busy, 0);
        chk("t5_ready", obs_ready, 0);
        chk("t5_rsp", obs_rsp, 0);
        step(0, 4'b0000, 4'b0000, 1, 1);
        chk("t5_late_rsp", obs_rsp, 0);
        dut_grants.delete();
        auto_rx = 1'b1;
        for (guard = 0; guard < 10 && dut_grants.size() < 1; guard++)
            step(0, 4'b1111, 4'b1111, 1, 0);
        chk("t5_grant_after_reset", (dut_grants.size() > 0) ? dut_grants[0] : -1, 0);

`ifdef SPI_ARB_TIMEOUT_EN
        // 1-word transaction whose read-back never comes
        step(1, 4'b0000, 4'b0000, 0, 0);
        auto_rx = 1'b0; sent = 0;
        for (guard = 0; guard < 10 && sent < 1; guard++) step(0, 4'b0010, 4'b0010, 1, 0);
        for (guard = 0; guard < 40; guard++) begin
            step(0, 4'b0000, 4'b0000, 1, 0);
            if (obs_terr) break;
        end
        // the pulse is seen in the cycle that starts TIMEOUT_CYC cycles after DRAIN entry
        chk("t6_timeout_delay", guard + 1, TIMEOUT_CYC + 1);
        dut_grants.delete();
        for (guard = 0; guard < 10 && dut_grants.size() < 1; guard++)
            step(0, 4'b1111, 4'b1111, 1, 0);
        chk("t6_next_grant", (dut_grants.size() > 0) ? dut_grants[0] : -1, 2);
`endif

        // random traffic against the model
        auto_rx = 1'b0;
        rv = 4'b0000;
        for (int n = 0; n < 800; n++) begin
            logic [NREQ-1:0] rl;
            if ($urandom_range(0, 4) == 0) rv = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++) rl[i] = ($urandom_range(0, 9) < 3);
            step(($urandom_range(0, 299) == 0), rv, rl,
                 ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 4));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
